// File: rtl/lcd_read_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared types and constants for the LCD read controller.
//            This package has no configuration macros.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  localparam int   LCD_DB_W    = 16;
  localparam logic LCD_RS_REG  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CS_SETUP = 4'd1,
    IDX_LO   = 4'd2,
    IDX_HI   = 4'd3,
    TURN     = 4'd4,
    RD_LO    = 4'd5,
    RD_HI    = 4'd6,
    FINISH   = 4'd7
  } lcd_rd_state_t;

  // Counter width needed to hold the largest of three strobe phase lengths.
  function automatic int lcd_cyc_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_read_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_read_ctrl_if
// Brief    : Command, read-stream and LCD pin bundle of the read controller.
//            LCD_READ_ABORT_EN adds the abort / aborted pair.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_read_ctrl_if #(
  parameter int CNT_W = 19
);
  import lcd_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [LCD_DB_W-1:0] cmd_reg;
  logic [CNT_W-1:0]    cmd_cnt;
  logic [1:0]          cmd_dummy;
  logic [LCD_DB_W-1:0] rdata;
  logic                rvalid;
  logic                rready;
  logic                busy;
  logic                done;
  logic                lcd_cs;
  logic                lcd_wr;
  logic                lcd_rd;
  logic                lcd_rs;
  logic [LCD_DB_W-1:0] db_o;
  logic                db_oe;
  logic [LCD_DB_W-1:0] db_i;
`ifdef LCD_READ_ABORT_EN
  logic                abort;
  logic                aborted;

  modport master (output cmd_valid, cmd_reg, cmd_cnt, cmd_dummy, rready, db_i, abort,
                  input  cmd_ready, rdata, rvalid, busy, done, lcd_cs, lcd_wr,
                         lcd_rd, lcd_rs, db_o, db_oe, aborted);
  modport slave  (input  cmd_valid, cmd_reg, cmd_cnt, cmd_dummy, rready, db_i, abort,
                  output cmd_ready, rdata, rvalid, busy, done, lcd_cs, lcd_wr,
                         lcd_rd, lcd_rs, db_o, db_oe, aborted);
`else
  modport master (output cmd_valid, cmd_reg, cmd_cnt, cmd_dummy, rready, db_i,
                  input  cmd_ready, rdata, rvalid, busy, done, lcd_cs, lcd_wr,
                         lcd_rd, lcd_rs, db_o, db_oe);
  modport slave  (input  cmd_valid, cmd_reg, cmd_cnt, cmd_dummy, rready, db_i,
                  output cmd_ready, rdata, rvalid, busy, done, lcd_cs, lcd_wr,
                         lcd_rd, lcd_rs, db_o, db_oe);
`endif

endinterface
`default_nettype wire

// File: rtl/lcd_read_ctrl_strobe_timer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_strobe_timer
// Brief    : Loadable down-counter. expire is high on the last cycle of a
//            loaded interval; idle is high once the count has run out.
//            This module has no configuration macros.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_strobe_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire,
  output logic         idle
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));
  assign idle   = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_read_ctrl
// Brief    : 8080-style LCD register read sequencer: index write, bus
//            turnaround, N read strobes with leading dummy reads discarded,
//            words delivered on a valid/ready stream.
//            LCD_READ_ABORT_EN adds an abort input and sticky aborted flag.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_read_ctrl
  import lcd_pkg::*;
#(
  parameter int CNT_W       = 19,
  parameter int WR_LOW_CYC  = 1,
  parameter int RD_LOW_CYC  = 4,
  parameter int RD_HIGH_CYC = 2
) (
  input  logic           clk,
  input  logic           rst,
  lcd_read_ctrl_if.slave bus
);

  localparam int TMR_W = lcd_cyc_w(WR_LOW_CYC, RD_LOW_CYC, RD_HIGH_CYC);

  lcd_rd_state_t       state_q, state_d;
  logic [LCD_DB_W-1:0] reg_q, reg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    delivered_q, delivered_d;
  logic [1:0]          dummy_left_q, dummy_left_d;
  logic [LCD_DB_W-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                done_q, done_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                rs_q, rs_d;
  logic                db_oe_q, db_oe_d;
`ifdef LCD_READ_ABORT_EN
  logic                aborted_q, aborted_d;
`endif

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expire;
  logic             tmr_idle;
  logic             sample_word;

  lcd_strobe_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire),
    .idle     (tmr_idle)
  );

  // Next state, datapath and pin values; pins derive from the next state so
  // they come straight out of flops aligned with the state register.
  always_comb begin
    state_d      = state_q;
    reg_d        = reg_q;
    cnt_d        = cnt_q;
    delivered_d  = delivered_q;
    dummy_left_d = dummy_left_q;
    rdata_d      = rdata_q;
    rvalid_d     = rvalid_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    sample_word  = 1'b0;
`ifdef LCD_READ_ABORT_EN
    aborted_d    = aborted_q;
`endif
    if (rvalid_q && bus.rready) begin
      rvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          reg_d        = bus.cmd_reg;
          cnt_d        = bus.cmd_cnt;
          dummy_left_d = bus.cmd_dummy;
          delivered_d  = '0;
          state_d      = CS_SETUP;
`ifdef LCD_READ_ABORT_EN
          aborted_d    = 1'b0;
`endif
        end
      end
      CS_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(WR_LOW_CYC);
        state_d  = IDX_LO;
      end
      IDX_LO: begin
        if (tmr_expire) begin
          state_d = IDX_HI;
        end
      end
      IDX_HI: begin
        state_d = (cnt_q == '0) ? FINISH : TURN;
      end
      TURN: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(RD_LOW_CYC);
        state_d  = RD_LO;
      end
      RD_LO: begin
        if (tmr_expire) begin
          if (dummy_left_q != 2'd0) begin
            dummy_left_d = dummy_left_q - 2'd1;
          end else begin
            sample_word = 1'b1;
            rdata_d     = bus.db_i;
            rvalid_d    = 1'b1;
            if (delivered_q != cnt_q) begin
              delivered_d = delivered_q + CNT_W'(1);
            end
          end
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(RD_HIGH_CYC);
          state_d  = RD_HI;
        end
      end
      RD_HI: begin
        // Hold the bus quiet until the pending word has been taken.
        if ((tmr_expire || tmr_idle) && (!rvalid_q || bus.rready)) begin
          if (delivered_q == cnt_q) begin
            state_d = FINISH;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(RD_LOW_CYC);
            state_d  = RD_LO;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef LCD_READ_ABORT_EN
    if (bus.abort && (state_q != IDLE) && (state_q != FINISH)) begin
      state_d   = FINISH;
      rvalid_d  = 1'b0;
      aborted_d = 1'b1;
    end
`endif

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
    cs_d        = (state_d == IDLE) || (state_d == FINISH);
    wr_d        = (state_d != IDX_LO);
    rd_d        = (state_d != RD_LO);
    db_oe_d     = (state_d == CS_SETUP) || (state_d == IDX_LO) || (state_d == IDX_HI);
    rs_d        = db_oe_d ? LCD_RS_REG : LCD_RS_DATA;
  end

  // State, datapath and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      reg_q        <= '0;
      cnt_q        <= '0;
      delivered_q  <= '0;
      dummy_left_q <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      cs_q         <= 1'b1;
      wr_q         <= 1'b1;
      rd_q         <= 1'b1;
      rs_q         <= LCD_RS_DATA;
      db_oe_q      <= 1'b0;
`ifdef LCD_READ_ABORT_EN
      aborted_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      reg_q        <= reg_d;
      cnt_q        <= cnt_d;
      delivered_q  <= delivered_d;
      dummy_left_q <= dummy_left_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      done_q       <= done_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      rs_q         <= rs_d;
      db_oe_q      <= db_oe_d;
`ifdef LCD_READ_ABORT_EN
      aborted_q    <= aborted_d;
`endif
    end
  end

  // A fresh sample must never land while the previous word is being taken.
  a_no_sample_on_accept : assert property (@(posedge clk) disable iff (rst)
    !(sample_word && rvalid_q && bus.rready));

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.lcd_cs    = cs_q;
  assign bus.lcd_wr    = wr_q;
  assign bus.lcd_rd    = rd_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.db_o      = reg_q;
  assign bus.db_oe     = db_oe_q;
`ifdef LCD_READ_ABORT_EN
  assign bus.aborted   = aborted_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_read_ctrl
// Brief    : Self-checking bench for lcd_read_ctrl with an LCD bus model and
//            a read-word scoreboard. LCD_READ_ABORT_EN enables abort tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_read_ctrl;
  import lcd_pkg::*;

  localparam int CNT_W       = 19;
  localparam int WR_LOW_CYC  = 1;
  localparam int RD_LOW_CYC  = 4;
  localparam int RD_HIGH_CYC = 2;

  logic clk = 1'b0;
  logic rst;

  lcd_read_ctrl_if #(.CNT_W(CNT_W)) bus ();

  lcd_read_ctrl #(
    .CNT_W       (CNT_W),
    .WR_LOW_CYC  (WR_LOW_CYC),
    .RD_LOW_CYC  (RD_LOW_CYC),
    .RD_HIGH_CYC (RD_HIGH_CYC)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] pdata[$];

  int   cyc = 0, acc_cyc = 0, done_cyc = 0;
  int   accepts = 0, done_cnt = 0, words_seen = 0, rd_pulses = 0, wr_pulses = 0;
  int   oe_conflicts = 0, low_len = 0, high_len = 0, dummy_rem = 0;
  logic rd_prev = 1'b1, wr_prev = 1'b1;
  logic [15:0] exp_reg = '0;
  logic [15:0] val;

  int w0, p0, d0, wp0, a0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus model, pulse timing monitor and read-stream scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rd_prev   = 1'b1;
      wr_prev   = 1'b1;
      low_len   = 0;
      high_len  = 0;
      dummy_rem = 0;
      bus.db_i  = 16'h0;
      exp_q.delete();
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        accepts++;
        acc_cyc   = cyc;
        exp_reg   = bus.cmd_reg;
        dummy_rem = int'(bus.cmd_dummy);
      end
      if (!bus.lcd_rd && bus.db_oe) oe_conflicts++;
      if (!bus.lcd_rd) begin
        if (rd_prev) begin
          rd_pulses++;
          if (high_len > 0) check_eq("rd_high_min", 32'(high_len >= RD_HIGH_CYC), 32'd1);
          low_len  = 1;
          bus.db_i = 16'($urandom);
        end else begin
          low_len++;
        end
        // Data becomes valid only in the last low cycle (slow panel access).
        if (low_len == RD_LOW_CYC) begin
          val = (pdata.size() > 0) ? pdata.pop_front() : 16'($urandom);
          bus.db_i = val;
          if (dummy_rem > 0) dummy_rem--;
          else exp_q.push_back(val);
        end
      end else begin
        if (!rd_prev) begin
          check_eq("rd_low_cyc", 32'(low_len), 32'(RD_LOW_CYC));
          high_len = 1;
          bus.db_i = 16'($urandom);
        end else begin
          high_len++;
        end
      end
      rd_prev = bus.lcd_rd;

      if (!bus.lcd_wr) begin
        if (wr_prev) wr_pulses++;
        check_eq("idx_db", 32'(bus.db_o), 32'(exp_reg));
        check_eq("idx_rs", 32'(bus.lcd_rs), 32'(LCD_RS_REG));
        check_eq("idx_oe", 32'(bus.db_oe), 32'd1);
        check_eq("idx_cs", 32'(bus.lcd_cs), 32'd0);
      end
      wr_prev = bus.lcd_wr;

      if (bus.rvalid && bus.rready) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
        else check_eq("rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
        words_seen++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic snap();
    w0 = words_seen; p0 = rd_pulses; d0 = done_cnt; wp0 = wr_pulses; a0 = accepts;
  endtask

  task automatic start_cmd(input logic [15:0] r, input logic [CNT_W-1:0] n, input logic [1:0] dmy);
    @(posedge clk); #1;
    bus.cmd_reg   = r;
    bus.cmd_cnt   = n;
    bus.cmd_dummy = dmy;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d = done_cnt;
    int i = 0;
    while (done_cnt == d && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check_eq("done_seen", 32'(done_cnt != d), 32'd1);
  endtask

  task automatic wait_words(input int target, input int budget);
    int i = 0;
    while (words_seen < target && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check_eq("words_reached", 32'(words_seen >= target), 32'd1);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int i = 0;
    while (rd_pulses < target && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check_eq("pulses_reached", 32'(rd_pulses >= target), 32'd1);
  endtask

  initial begin
    logic [15:0] hold;
    logic        held;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_reg   = '0;
    bus.cmd_cnt   = '0;
    bus.cmd_dummy = '0;
    bus.rready    = 1'b1;
`ifdef LCD_READ_ABORT_EN
    bus.abort     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_cs",     32'(bus.lcd_cs), 32'd1);
    check_eq("rst_wr",     32'(bus.lcd_wr), 32'd1);
    check_eq("rst_rd",     32'(bus.lcd_rd), 32'd1);
    check_eq("rst_rs",     32'(bus.lcd_rs), 32'd1);
    check_eq("rst_oe",     32'(bus.db_oe),  32'd0);
    check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("rst_done",   32'(bus.done),   32'd0);
    check_eq("rst_busy",   32'(bus.busy),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_eq("idle_ready", 32'(bus.cmd_ready), 32'd1);

    // T1: one dummy read then three words.
    pdata.push_back(16'h1111); pdata.push_back(16'h0000);
    pdata.push_back(16'h9341); pdata.push_back(16'h00AA);
    snap();
    start_cmd(16'h00D3, 19'd3, 2'd1);
    wait_done(200);
    check_eq("t1_words",  32'(words_seen - w0), 32'd3);
    check_eq("t1_pulses", 32'(rd_pulses - p0),  32'd4);
    check_eq("t1_done",   32'(done_cnt - d0),   32'd1);
    check_eq("t1_wr",     32'(wr_pulses - wp0), 32'd1);
    check_eq("t1_sb",     32'(exp_q.size()),    32'd0);
    @(negedge clk); #1;
    check_eq("t1_done_pulse", 32'(bus.done), 32'd0);
    check_eq("t1_idle",       32'(bus.busy), 32'd0);

    // T2: index write only.
    snap();
    start_cmd(16'h0004, 19'd0, 2'd0);
    wait_done(50);
    check_eq("t2_wr",       32'(wr_pulses - wp0),   32'd1);
    check_eq("t2_pulses",   32'(rd_pulses - p0),    32'd0);
    check_eq("t2_words",    32'(words_seen - w0),   32'd0);
    check_eq("t2_done_lat", 32'(done_cyc - acc_cyc), 32'd4);

    // T3: backpressure after the first word.
    snap();
    start_cmd(16'h002E, 19'd4, 2'd0);
    wait_words(w0 + 1, 200);
    @(posedge clk); #1;
    bus.rready = 1'b0;
    held = 1'b0;
    hold = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.rvalid) begin
        if (!held) begin
          hold = bus.rdata;
          held = 1'b1;
        end
        check_eq("bp_rd",    32'(bus.lcd_rd), 32'd1);
        check_eq("bp_cs",    32'(bus.lcd_cs), 32'd0);
        check_eq("bp_rdata", 32'(bus.rdata),  32'(hold));
      end
    end
    check_eq("bp_word_held", 32'(held), 32'd1);
    @(posedge clk); #1;
    bus.rready = 1'b1;
    wait_done(200);
    check_eq("t3_words",  32'(words_seen - w0), 32'd4);
    check_eq("t3_pulses", 32'(rd_pulses - p0),  32'd4);
    check_eq("t3_sb",     32'(exp_q.size()),    32'd0);

    // T4: reset during the second read strobe.
    snap();
    start_cmd(16'h0009, 19'd3, 2'd0);
    wait_pulses(p0 + 2, 200);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check_eq("t4_cs",     32'(bus.lcd_cs), 32'd1);
    check_eq("t4_rd",     32'(bus.lcd_rd), 32'd1);
    check_eq("t4_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("t4_busy",   32'(bus.busy),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pdata.delete();
    pdata.push_back(16'hAAAA); pdata.push_back(16'h5A5A); pdata.push_back(16'hC3C3);
    snap();
    start_cmd(16'h000A, 19'd2, 2'd1);
    wait_done(200);
    check_eq("t4_words",  32'(words_seen - w0), 32'd2);
    check_eq("t4_pulses", 32'(rd_pulses - p0),  32'd3);
    check_eq("t4_done",   32'(done_cnt - d0),   32'd1);

    // T5: command attempts while busy are dropped.
    snap();
    start_cmd(16'h00DA, 19'd2, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_reg   = 16'h1234;
      bus.cmd_cnt   = 19'd7;
      bus.cmd_dummy = 2'd3;
      @(negedge clk); #1;
      check_eq("busy_ready", 32'(bus.cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_done(200);
    repeat (4) @(negedge clk);
    #1;
    check_eq("t5_busy",    32'(bus.busy),         32'd0);
    check_eq("t5_accepts", 32'(accepts - a0),     32'd1);
    check_eq("t5_pulses",  32'(rd_pulses - p0),   32'd2);
    check_eq("t5_words",   32'(words_seen - w0),  32'd2);
    check_eq("t5_oe_rd",   32'(oe_conflicts),     32'd0);

`ifdef LCD_READ_ABORT_EN
    // T6: abort in the high phase after word 2 of 5.
    snap();
    start_cmd(16'h000C, 19'd5, 2'd0);
    wait_words(w0 + 2, 200);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(negedge clk); #1;
    check_eq("t6_done",    32'(done_cnt - d0),  32'd1);
    check_eq("t6_aborted", 32'(bus.aborted),    32'd1);
    check_eq("t6_rvalid",  32'(bus.rvalid),     32'd0);
    check_eq("t6_rd",      32'(bus.lcd_rd),     32'd1);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_eq("t6_words",  32'(words_seen - w0), 32'd2);
    check_eq("t6_sticky", 32'(bus.aborted),     32'd1);
    check_eq("t6_idle",   32'(bus.busy),        32'd0);
    exp_q.delete();
    start_cmd(16'h000D, 19'd1, 2'd0);
    check_eq("t6_cleared", 32'(bus.aborted), 32'd0);
    wait_done(100);
`endif

    repeat (3) @(negedge clk);
    #1;
    check_eq("oe_conflicts", 32'(oe_conflicts), 32'd0);
    check_eq("sb_empty",     32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000 ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
